// File: rtl/registry_file_param_if.sv
// Register-file port bundle: two read ports, two write ports, one step port and status flags.
// The master side drives addresses/enables; the slave (register file) returns data and flags.
interface registry_file_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              write_en;

    logic [ADDR_W-1:0] write2_reg;
    logic [DATA_W-1:0] write2_data;
    logic              write2_en;

    logic              inc_en;
    logic [ADDR_W-1:0] inc_reg;
    logic              inc_dec;

    logic              inc_carry;
    logic              collision;

    modport master (
        output read_reg1, read_reg2,
        output write_reg, write_data, write_en,
        output write2_reg, write2_data, write2_en,
        output inc_en, inc_reg, inc_dec,
        input  read_data1, read_data2, inc_carry, collision
    );

    modport slave (
        input  read_reg1, read_reg2,
        input  write_reg, write_data, write_en,
        input  write2_reg, write2_data, write2_en,
        input  inc_en, inc_reg, inc_dec,
        output read_data1, read_data2, inc_carry, collision
    );
endinterface

// File: rtl/registry_file_param.sv
// Parametrised register file: two prioritised write ports (A > B > step), an atomic +/-1 step
// port, optional hardwired-zero r0 and optional write-to-read bypass on the async read ports.
module registry_file_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter bit          ZERO_REG  = 1'b0,
    parameter bit          BYPASS    = 1'b0,
    parameter logic [63:0] RESET_VAL = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    registry_file_param_if.slave bus
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] RST_V = RESET_VAL[DATA_W-1:0];

    logic [DATA_W-1:0] regs [DEPTH];
    logic              carry_q;
    logic              collision_q;

    logic              ab_hit;
    logic              ai_hit;
    logic              bi_hit;
    logic              collision_d;
    logic              a_en;
    logic              b_en;
    logic              i_en;
    logic [DATA_W-1:0] step_old;
    logic [DATA_W-1:0] step_val;
    logic              step_wrap;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Port conflict resolution: each lower-priority port is masked when a higher one hits its register.
    always_comb begin
        ab_hit      = bus.write_en  && bus.write2_en && (bus.write_reg  == bus.write2_reg);
        ai_hit      = bus.write_en  && bus.inc_en    && (bus.write_reg  == bus.inc_reg);
        bi_hit      = bus.write2_en && bus.inc_en    && (bus.write2_reg == bus.inc_reg);
        collision_d = ab_hit || ai_hit || bi_hit;

        a_en = bus.write_en  && !is_zero_reg(bus.write_reg);
        b_en = bus.write2_en && !ab_hit && !is_zero_reg(bus.write2_reg);
        i_en = bus.inc_en    && !ai_hit && !bi_hit && !is_zero_reg(bus.inc_reg);

        step_old  = regs[bus.inc_reg];
        step_val  = bus.inc_dec ? (step_old - DATA_W'(1)) : (step_old + DATA_W'(1));
        step_wrap = bus.inc_dec ? (step_old == '0) : (step_old == '1);
    end

    // Bypass returns exactly what the next edge commits, so it follows the same priority order;
    // during reset nothing commits and the stored value is shown instead.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs[addr];
        if (BYPASS && rst_n) begin
            if (bus.write_en && (bus.write_reg == addr)) begin
                val = bus.write_data;
            end else if (bus.write2_en && (bus.write2_reg == addr)) begin
                val = bus.write2_data;
            end else if (bus.inc_en && (bus.inc_reg == addr)) begin
                val = step_val;
            end
        end
        if (is_zero_reg(addr)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        bus.read_data1 = read_port(bus.read_reg1);
        bus.read_data2 = read_port(bus.read_reg2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= RST_V;
            end
            carry_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (a_en) begin
                regs[bus.write_reg] <= bus.write_data;
            end
            if (b_en) begin
                regs[bus.write2_reg] <= bus.write2_data;
            end
            if (i_en) begin
                regs[bus.inc_reg] <= step_val;
                carry_q           <= step_wrap;
            end
            collision_q <= collision_d;
        end
    end

    assign bus.inc_carry = carry_q;
    assign bus.collision = collision_q;

endmodule

// File: doc/registry_file_param.md
Name: registry_file_param

Overview:
- Parametrised successor of the 8x8 register file.
- Configurable data width and register count.
- Two write ports with fixed priority, plus an atomic increment/decrement port for pointer-style registers (SP, loop counters).
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Sits in the CPU datapath between decode/writeback and the ALU operand muxes.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, register address width; depth = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores all writes
BYPASS, 0, 1 = a read of a register being written this cycle returns the value to be written
RESET_VAL, 0, value loaded into every register on reset (truncated to DATA_W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
read_reg1  input  ADDR_W  read port 1 address
read_reg2  input  ADDR_W  read port 2 address
read_data1  output  DATA_W  read port 1 data (combinational)
read_data2  output  DATA_W  read port 2 data (combinational)
write_reg  input  ADDR_W  write port A address
write_data  input  DATA_W  write port A data
write_en  input  1  write port A enable
write2_reg  input  ADDR_W  write port B address
write2_data  input  DATA_W  write port B data
write2_en  input  1  write port B enable
inc_en  input  1  step enable for inc_reg
inc_reg  input  ADDR_W  register to step
inc_dec  input  1  0 = +1, 1 = -1
inc_carry  output  1  registered: last step wrapped (0xFF->0x00 on inc, 0x00->0xFF on dec)
collision  output  1  registered: previous cycle had two or more enabled ports on the same register

Behaviour:
- Reset (rst_n=0 at rising edge): every register = RESET_VAL; inc_carry=0; collision=0. All port enables are ignored during that cycle. Reset asserted mid-sequence overrides any pending write or step.
- Reads: asynchronous, zero latency.
  - BYPASS=0: returns the stored value; a write appears on read_data the cycle after the edge.
  - BYPASS=1: read address matches an enabled write/step target → output the value that will be committed at the next edge, after the priority rules below. Otherwise the stored value.
  - ZERO_REG=1: address 0 reads 0 regardless of BYPASS.
- Writes: commit on the rising edge when rst_n=1.
  - Ports targeting distinct registers all commit in the same cycle.
  - Same-register priority: write port A > write port B > inc port. Lower-priority ports are dropped for that register.
  - collision=1 on the following cycle whenever two or more enabled ports share an address. Applies even if ZERO_REG suppresses the write.
- Step: new = old +/- 1 modulo 2**DATA_W, based on the value stored before the edge.
  - inc_carry updates only on a cycle where inc_en=1 and the step is not suppressed. Otherwise it holds.
  - A step suppressed by a higher-priority write leaves inc_carry unchanged.
  - ZERO_REG=1 with inc_reg=0: step suppressed, inc_carry unchanged.
- ZERO_REG=1: writes to register 0 are discarded; stored content is irrelevant.
- X-free: no output depends on unwritten storage after reset.

Test Plan:
1. Reset with RESET_VAL=0, read_reg1=0, read_reg2=1 → both reads 0x00, inc_carry=0, collision=0.
2. Port A writes 0xAA to r0, port B writes 0x55 to r1 in the same cycle (BYPASS=0) → next cycle read_data1=0xAA, read_data2=0x55; during the write cycle both reads still 0x00.
3. Port A writes 0x11 to r3, port B writes 0x22 to r3, inc_en on r3 → r3=0x11, collision=1 for one cycle, then 0.
4. r5=0xFF, inc_en=1, inc_dec=0 → r5=0x00, inc_carry=1. Then inc_dec=1 → r5=0xFF, inc_carry=1. Then inc_dec=1 again → r5=0xFE, inc_carry=0.
5. BYPASS=1: write 0x3C to r2 with read_reg1=2 → read_data1=0x3C in the same cycle, before the edge. ZERO_REG=1: write 0x77 to r0 → read_data of r0 stays 0x00.
6. Write 0x99 to r4 while rst_n=0 → r4 remains RESET_VAL. Deassert rst_n and repeat the write → r4=0x99 next cycle.
